// File: rtl/led_cnt_meas_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_cnt_pkg (package)
//  Description : Shared types and helpers for the led_cnt LED period decoder.
//                - meas_state_t : measurement FSM state encoding
//                - DIV_W        : width of the decoded divider output
//                - msb_idx()    : index of the highest set bit (floor log2),
//                                 0 for an all-zero argument
//  Revision    : 1.0 - initial release
// ============================================================================
package led_cnt_pkg;

    localparam int DIV_W = 5;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_MEAS  = 2'd1,
        S_STALL = 2'd2
    } meas_state_t;

    // Highest set bit position of a 64-bit value; 0 when the value is 0.
    function automatic logic [7:0] msb_idx(input logic [63:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 64; i++) begin
            if (v[i]) begin
                r = 8'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_cnt_meas_log2.sv
`default_nettype none
// ============================================================================
//  Module      : led_cnt_meas_log2
//  Description : Combinational period-to-divider decoder.
//                o_div = floor(log2(i_period >> 1)), 0 when i_period < 2,
//                clamped to 31, and forced to 31 for a saturated (all-ones)
//                period. The parent registers the result.
//  Ports       : i_period [CNT_W-1:0]  period in clock cycles
//                o_div    [DIV_W-1:0]  decoded divider setting
//  Revision    : 1.0 - initial release
// ============================================================================
module led_cnt_meas_log2
    import led_cnt_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic [CNT_W-1:0] i_period,
    output logic [DIV_W-1:0] o_div
);

    localparam logic [7:0] c_div_max = 8'd31;

    logic [63:0] w_half;
    logic [7:0]  w_msb;

    always_comb begin
        w_half = 64'(i_period >> 1);
        w_msb  = msb_idx(w_half);
        // A saturated counter means "longer than measurable": report the top code.
        if (&i_period) begin
            o_div = 5'd31;
        end else if (w_msb > c_div_max) begin
            o_div = 5'd31;
        end else begin
            o_div = w_msb[DIV_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/led_cnt_meas.sv
`default_nettype none
// ============================================================================
//  Module      : led_cnt_meas
//  Description : Decoder side of the led_cnt LED counter. Measures the period
//                between rising edges of led_i[SEL] in clk100 cycles, decodes
//                the divider setting, flags lock after LOCK_N equal periods
//                and stall after TIMEOUT cycles without a rising edge.
//  Config      : LED_CNT_MEAS_SYNC_EN - when defined, led_i[SEL] passes a
//                2-FF synchronizer first (+2 cycles edge-to-valid latency).
//  Ports       : clk100   in   system clock
//                rst      in   synchronous reset, active-high
//                led_i    in   LED bus from led_cnt
//                clr_i    in   synchronous soft clear (same as rst)
//                period_o out  last measured period
//                div_o    out  decoded divider
//                valid_o  out  one-cycle pulse on period_o/div_o update
//                lock_o   out  LOCK_N consecutive identical periods seen
//                stall_o  out  no rising edge for TIMEOUT cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module led_cnt_meas
    import led_cnt_pkg::*;
#(
    parameter int LED_W   = 4,
    parameter int SEL     = 0,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 2**27,
    parameter int LOCK_N  = 3
) (
    input  logic             clk100,
    input  logic             rst,
    input  logic [LED_W-1:0] led_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] period_o,
    output logic [DIV_W-1:0] div_o,
    output logic             valid_o,
    output logic             lock_o,
    output logic             stall_o
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);
    localparam logic [7:0]       c_lock_m1 = 8'(LOCK_N - 1);

    logic             w_clr;
    logic             w_led;
    logic             w_rise;
    logic             w_timeout;
    logic             w_same;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [7:0]       w_match_inc;
    logic [7:0]       w_match_nxt;
    logic [DIV_W-1:0] w_div;
    logic             w_unused_led;

    logic             r_led_q;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_match;
    meas_state_t      r_state;
    logic [CNT_W-1:0] r_period;
    logic [DIV_W-1:0] r_div;
    logic             r_valid;
    logic             r_lock;
    logic             r_stall;

    // Soft clear behaves exactly like reset.
    assign w_clr = rst | clr_i;

    // Only led_i[SEL] is observed; the rest of the bus is intentionally ignored.
    assign w_unused_led = ^led_i;

`ifdef LED_CNT_MEAS_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge clk100) begin
        if (w_clr) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= led_i[SEL];
            r_sync2 <= r_sync1;
        end
    end

    assign w_led = r_sync2;
`else
    assign w_led = led_i[SEL];
`endif

    // r_led_q resets low, so a level already high at reset exit reads as a rise.
    assign w_rise    = w_led & ~r_led_q;
    assign w_cnt_inc = (r_cnt == c_cnt_max) ? r_cnt : r_cnt + c_cnt_one;

    // r_cnt equals the number of cycles since the last rise, so it is both
    // the idle count and the candidate period.
    assign w_timeout = (r_cnt >= c_timeout);
    assign w_same    = (r_cnt == r_period);

    // Match count saturates at LOCK_N-1 so it cannot wrap while locked.
    assign w_match_inc = (r_match >= c_lock_m1) ? r_match : r_match + 8'd1;
    assign w_match_nxt = w_same ? w_match_inc : 8'd0;

    led_cnt_meas_log2 #(
        .CNT_W (CNT_W)
    ) u_log2 (
        .i_period (r_cnt),
        .o_div    (w_div)
    );

    always_ff @(posedge clk100) begin
        if (w_clr) begin
            r_led_q  <= 1'b0;
            r_cnt    <= '0;
            r_match  <= '0;
            r_state  <= S_WAIT;
            r_period <= '0;
            r_div    <= '0;
            r_valid  <= 1'b0;
            r_lock   <= 1'b0;
            r_stall  <= 1'b0;
        end else begin
            r_led_q <= w_led;
            r_cnt   <= w_rise ? c_cnt_one : w_cnt_inc;
            r_valid <= 1'b0;

            case (r_state)
                S_WAIT: begin
                    // First edge only starts the count; there is no period yet.
                    if (w_rise) begin
                        r_state <= S_MEAS;
                    end
                end
                S_MEAS: begin
                    // A rise in the same cycle as the timeout takes priority.
                    if (w_rise) begin
                        r_period <= r_cnt;
                        r_div    <= w_div;
                        r_valid  <= 1'b1;
                        r_match  <= w_match_nxt;
                        r_lock   <= (w_match_nxt >= c_lock_m1);
                    end else if (w_timeout) begin
                        r_state <= S_STALL;
                        r_stall <= 1'b1;
                        r_lock  <= 1'b0;
                        r_match <= '0;
                    end
                end
                S_STALL: begin
                    // Resume edge restarts the count but has no valid period.
                    if (w_rise) begin
                        r_state <= S_MEAS;
                        r_stall <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_WAIT;
                end
            endcase
        end
    end

    assign period_o = r_period;
    assign div_o    = r_div;
    assign valid_o  = r_valid;
    assign lock_o   = r_lock;
    assign stall_o  = r_stall;

endmodule
`default_nettype wire

// File: tb/tb_led_cnt_meas.sv
`default_nettype none
// ============================================================================
//  Module      : tb_led_cnt_meas
//  Description : Directed self-checking bench for led_cnt_meas. Drives LED
//                waveforms on led_i[0] and checks period/div/valid/lock/stall
//                against hand-computed values. Edge-to-valid latency adapts to
//                LED_CNT_MEAS_SYNC_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_led_cnt_meas;

`ifdef LED_CNT_MEAS_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic        clk100;
    logic        rst;
    logic [3:0]  led;
    logic        clr;
    logic [31:0] period_o;
    logic [4:0]  div_o;
    logic        valid_o;
    logic        lock_o;
    logic        stall_o;

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int vsnap;

    logic        cap_pv, cap_v, cap_va, cap_lk, cap_st;
    logic [31:0] cap_p;
    logic [4:0]  cap_d;

    led_cnt_meas #(
        .LED_W   (4),
        .SEL     (0),
        .CNT_W   (32),
        .TIMEOUT (100),
        .LOCK_N  (3)
    ) dut (
        .clk100   (clk100),
        .rst      (rst),
        .led_i    (led),
        .clr_i    (clr),
        .period_o (period_o),
        .div_o    (div_o),
        .valid_o  (valid_o),
        .lock_o   (lock_o),
        .stall_o  (stall_o)
    );

    initial clk100 = 1'b0;
    always #5 clk100 = ~clk100;

    // Count valid pulses, sampled mid-cycle.
    always @(negedge clk100) begin
        if (valid_o === 1'b1) vcnt++;
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Independent decode model: floor(log2(p>>1)), 0 below 2, 31 cap / saturation.
    function automatic logic [63:0] exp_div(input logic [63:0] p);
        logic [63:0] h;
        int          r;
        if (p == 64'hFFFF_FFFF) return 64'd31;
        h = p >> 1;
        r = 0;
        while (h > 64'd1) begin
            h = h >> 1;
            r++;
        end
        if (r > 31) r = 31;
        return 64'(r);
    endfunction

    // One LED period starting with a rise: hi cycles high, lo cycles low.
    // Captures outputs one cycle before, at, and one cycle after the point
    // where this rise's valid_o is due. Upper LED bits carry a fixed pattern.
    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi + lo; i++) begin
            led = (i < hi) ? 4'b1011 : 4'b1010;
            if (i == LAT - 1) cap_pv = valid_o;
            tick();
            if (i == LAT - 1) begin
                cap_v  = valid_o;
                cap_p  = period_o;
                cap_d  = div_o;
                cap_lk = lock_o;
                cap_st = stall_o;
            end
            if (i == LAT) cap_va = valid_o;
        end
    endtask

    initial begin
        rst = 1'b1;
        clr = 1'b0;
        led = 4'b1010;

        // ---------------- reset ----------------
        tick();
        tick();
        chk("rst_period", period_o, 0);
        chk("rst_div",    div_o,    0);
        chk("rst_valid",  valid_o,  0);
        chk("rst_lock",   lock_o,   0);
        chk("rst_stall",  stall_o,  0);
        rst = 1'b0;
        tick();

        // ---------------- test 1: period 8 ----------------
        pulse(4, 4);
        chk("t1_first_edge_no_valid", cap_v, 0);
        pulse(4, 4);
        chk("t1_valid_pre",  cap_pv, 0);
        chk("t1_valid",      cap_v,  1);
        chk("t1_valid_post", cap_va, 0);
        chk("t1_period",     cap_p,  8);
        chk("t1_div",        cap_d,  2);
        chk("t1_lock_r2",    cap_lk, 0);
        pulse(4, 4);
        chk("t1_lock_r3",    cap_lk, 0);
        pulse(4, 4);
        chk("t1_lock_r4",    cap_lk, 1);
        chk("t1_period_r4",  cap_p,  8);

        // ---------------- test 2: 8 -> 12 ----------------
        pulse(6, 6);
        chk("t2_still_locked", cap_lk, 1);
        pulse(6, 6);
        chk("t2_valid12",  cap_v,  1);
        chk("t2_period12", cap_p,  12);
        chk("t2_div12",    cap_d,  2);
        chk("t2_unlock",   cap_lk, 0);
        pulse(6, 6);
        chk("t2_lock_m1",  cap_lk, 0);
        pulse(6, 6);
        chk("t2_relock",   cap_lk, 1);

        // ---------------- test 3: stall ----------------
        led = 4'b1011;
        for (int i = 0; i < LAT; i++) tick();
        chk("t3_last_valid",  valid_o,  1);
        chk("t3_last_period", period_o, 12);
        chk("t3_last_lock",   lock_o,   1);
        vsnap = vcnt;
        for (int i = 0; i < 6; i++) tick();
        led = 4'b1010;
        for (int i = 0; i < 93; i++) tick();
        chk("t3_stall_at99",  stall_o, 0);
        chk("t3_lock_at99",   lock_o,  1);
        tick();
        chk("t3_stall_at100", stall_o,  1);
        chk("t3_lock_at100",  lock_o,   0);
        chk("t3_period_held", period_o, 12);
        chk("t3_div_held",    div_o,    2);
        pulse(4, 4);
        chk("t3_resume_no_valid",    cap_v,  0);
        chk("t3_resume_stall_clear", cap_st, 0);
        chk("t3_no_valid_in_stall",  vcnt,   vsnap + 1);
        pulse(4, 4);
        chk("t3_resume_valid2",  cap_v, 1);
        chk("t3_resume_period",  cap_p, 8);

        // ---------------- test 4: led_cnt div=1 style (period 4) + bounds ----------------
        pulse(2, 2);
        pulse(2, 2);
        chk("t4_period4", cap_p, 4);
        chk("t4_div4",    cap_d, exp_div(64'd4));
        pulse(1, 1);
        pulse(32, 32);
        chk("t4_period2", cap_p, 2);
        chk("t4_div2",    cap_d, exp_div(64'd2));
        pulse(4, 4);
        chk("t4_period64", cap_p, 64);
        chk("t4_div64",    cap_d, exp_div(64'd64));

        // ---------------- test 5: soft clear ----------------
        led = 4'b1011;
        for (int i = 0; i < 4; i++) tick();
        led = 4'b1010;
        tick();
        tick();
        chk("t5_pre_period", period_o, 8);
        vsnap = vcnt;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("t5_clr_period", period_o, 0);
        chk("t5_clr_div",    div_o,    0);
        chk("t5_clr_valid",  valid_o,  0);
        chk("t5_clr_lock",   lock_o,   0);
        chk("t5_clr_stall",  stall_o,  0);
        for (int i = 0; i < 4; i++) tick();
        pulse(4, 4);
        chk("t5_first_no_valid", cap_v, 0);
        pulse(4, 4);
        chk("t5_second_valid",   cap_v,  1);
        chk("t5_second_period",  cap_p,  8);
        chk("t5_second_lock",    cap_lk, 0);
        chk("t5_one_valid",      vcnt,   vsnap + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
